// File: rtl/gpio_cfg_chain_ctrl_if.sv
// gpio_cfg_chain_ctrl_if
// Register-bus side of the GPIO pad configuration chain master. It groups the
// shadow-register access, the sequence control and the status signals.
//   master : SoC register bus. It drives cfg_wr/cfg_addr/cfg_wdata/start/clk_div
//            and observes cfg_rdata/busy/done/rb_mismatch.
//   slave  : the chain controller. It has the opposite directions.
interface gpio_cfg_chain_ctrl_if #(
  parameter int NUM_PADS  = 6,
  parameter int CTRL_BITS = 16,
  parameter int DIV_W     = 8
);

  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  logic                 cfg_wr;       // shadow write strobe
  logic [AW-1:0]        cfg_addr;     // pad index for write/read
  logic [CTRL_BITS-1:0] cfg_wdata;    // shadow write data
  logic [CTRL_BITS-1:0] cfg_rdata;    // shadow word at cfg_addr, 0 when out of range
  logic                 start;        // single-cycle request for a shift+load sequence
  logic [DIV_W-1:0]     clk_div;      // serial_clock half-period minus 1, in mclk cycles
  logic                 busy;         // sequence in progress
  logic                 done;         // one-cycle pulse at sequence end
  logic                 rb_mismatch;  // sticky readback error flag

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, start, clk_div,
    input  cfg_rdata, busy, done, rb_mismatch
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, start, clk_div,
    output cfg_rdata, busy, done, rb_mismatch
  );

endinterface

// File: rtl/gpio_cfg_chain_ctrl.sv
// gpio_cfg_chain_ctrl
// Master for the daisy-chained GPIO pad configuration shift chain. It keeps one
// CTRL_BITS shadow word per pad. On start it shifts the whole image into the
// chain, with pad NUM_PADS-1 first and the MSB first within each word. The bit
// rate is programmable. After the shift it pulses serial_load. The bits that
// come back from the chain tail are compared against the image committed by
// the previous sequence, and any difference sets the sticky rb_mismatch flag.
// Ports:
//   mclk, reset        : block clock, synchronous active-high reset
//   bus (slave)        : shadow access, start/clk_div, busy/done/rb_mismatch
//   serial_shift_rstn  : chain shift-register reset (active low, registered ~reset)
//   serial_clock       : chain shift clock
//   serial_load        : chain load strobe
//   serial_data_out    : data into the chain head
//   serial_data_in     : data from the chain tail
module gpio_cfg_chain_ctrl #(
  parameter int                   NUM_PADS    = 6,
  parameter int                   CTRL_BITS   = 16,
  parameter int                   DIV_W       = 8,
  parameter logic [CTRL_BITS-1:0] DEFAULT_CFG = 16'h3000
) (
  input  logic                 mclk,
  input  logic                 reset,
  gpio_cfg_chain_ctrl_if.slave bus,
  output logic                 serial_shift_rstn,
  output logic                 serial_clock,
  output logic                 serial_load,
  output logic                 serial_data_out,
  input  logic                 serial_data_in
);

  localparam int                   CHAIN_LEN     = NUM_PADS * CTRL_BITS;
  localparam int                   KW            = $clog2(CHAIN_LEN + 1);
  localparam int                   AW            = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam logic [KW-1:0]        LAST_BIT      = KW'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0] DEFAULT_IMAGE = {NUM_PADS{DEFAULT_CFG}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_GAP      = 3'd3,
    S_LOAD     = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  // Stream bit k of a flattened image. Pad NUM_PADS-1 occupies the top of the
  // image, so stream bit k is image[CHAIN_LEN-1-k]. A shift is used instead of
  // an index so the index width never has to match the image size.
  function automatic logic stream_bit(input logic [CHAIN_LEN-1:0] image,
                                      input logic [KW-1:0]        k);
    logic [CHAIN_LEN-1:0] shifted;
    shifted = image >> (LAST_BIT - k);
    return shifted[0];
  endfunction

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       phase_q, phase_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [KW-1:0]          bit_q, bit_d;
  logic [CTRL_BITS-1:0]   shadow_q [NUM_PADS];
  logic [CTRL_BITS-1:0]   shadow_d [NUM_PADS];
  logic [CHAIN_LEN-1:0]   commit_q, commit_d;
  logic                   commit_valid_q, commit_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mismatch_q, mismatch_d;
  logic                   sclk_q, sclk_d;
  logic                   sload_q, sload_d;
  logic                   sdo_q, sdo_d;
  logic                   srstn_q;

  logic [CHAIN_LEN-1:0]   image_s;
  logic [CTRL_BITS-1:0]   rdata_s;
  logic                   last_phase_s;

  // Flatten the shadow file into the image in stream order.
  always_comb begin
    image_s = {CHAIN_LEN{1'b0}};
    for (int p = 0; p < NUM_PADS; p++) begin
      image_s[p*CTRL_BITS +: CTRL_BITS] = shadow_q[p];
    end
  end

  // Combinational shadow read. Addresses past the last pad read as zero.
  always_comb begin
    rdata_s = {CTRL_BITS{1'b0}};
    for (int p = 0; p < NUM_PADS; p++) begin
      if (bus.cfg_addr == AW'(p)) begin
        rdata_s = shadow_q[p];
      end else begin
        rdata_s = rdata_s;
      end
    end
  end

  // Shadow writes land only while idle, so the image is frozen while it shifts.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.cfg_wr && (state_q == S_IDLE)) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (bus.cfg_addr == AW'(p)) begin
          shadow_d[p] = bus.cfg_wdata;
        end else begin
          shadow_d[p] = shadow_q[p];
        end
      end
    end else begin
      shadow_d = shadow_q;
    end
  end

  assign last_phase_s = (phase_q == div_q);

  // Sequencer next state: each non-idle timed state lasts div_q+1 cycles.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    div_d          = div_q;
    bit_d          = bit_q;
    commit_d       = commit_q;
    commit_valid_d = commit_valid_q;
    mismatch_d     = mismatch_q;
    case (state_q)
      S_IDLE: begin
        phase_d = {DIV_W{1'b0}};
        if (bus.start) begin
          div_d      = bus.clk_div;
          mismatch_d = 1'b0;
          bit_d      = {KW{1'b0}};
          state_d    = S_SHIFT_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT_LO: begin
        if (last_phase_s) begin
          phase_d = {DIV_W{1'b0}};
          state_d = S_SHIFT_HI;
          // The tail is sampled just before the rising edge that would shift
          // it out, so it still holds the previously loaded bit k.
          if (commit_valid_q && (serial_data_in != stream_bit(commit_q, bit_q))) begin
            mismatch_d = 1'b1;
          end else begin
            mismatch_d = mismatch_q;
          end
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      S_SHIFT_HI: begin
        if (last_phase_s) begin
          phase_d = {DIV_W{1'b0}};
          bit_d   = bit_q + KW'(1);
          if (bit_q == LAST_BIT) begin
            state_d = S_GAP;
          end else begin
            state_d = S_SHIFT_LO;
          end
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (last_phase_s) begin
          phase_d = {DIV_W{1'b0}};
          state_d = S_LOAD;
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      S_LOAD: begin
        if (last_phase_s) begin
          phase_d        = {DIV_W{1'b0}};
          commit_d       = image_s;
          commit_valid_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        phase_d = {DIV_W{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        phase_d = {DIV_W{1'b0}};
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they are registered and
  // line up exactly with the state they describe.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sclk_d  = 1'b0;
    sload_d = 1'b0;
    sdo_d   = 1'b0;
    case (state_d)
      S_SHIFT_LO: begin
        busy_d = 1'b1;
        // New data is presented only on entry and held through the high phase.
        if (state_q == S_SHIFT_LO) begin
          sdo_d = sdo_q;
        end else begin
          sdo_d = stream_bit(image_s, bit_d);
        end
      end
      S_SHIFT_HI: begin
        busy_d = 1'b1;
        sclk_d = 1'b1;
        sdo_d  = sdo_q;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_LOAD: begin
        busy_d  = 1'b1;
        sload_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      S_IDLE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, shadow file, committed image and registered outputs.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      phase_q        <= {DIV_W{1'b0}};
      div_q          <= {DIV_W{1'b0}};
      bit_q          <= {KW{1'b0}};
      for (int p = 0; p < NUM_PADS; p++) begin
        shadow_q[p] <= DEFAULT_CFG;
      end
      commit_q       <= DEFAULT_IMAGE;
      commit_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mismatch_q     <= 1'b0;
      sclk_q         <= 1'b0;
      sload_q        <= 1'b0;
      sdo_q          <= 1'b0;
      srstn_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      shadow_q       <= shadow_d;
      commit_q       <= commit_d;
      commit_valid_q <= commit_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mismatch_q     <= mismatch_d;
      sclk_q         <= sclk_d;
      sload_q        <= sload_d;
      sdo_q          <= sdo_d;
      srstn_q        <= 1'b1;
    end
  end

  assign bus.cfg_rdata      = rdata_s;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.rb_mismatch    = mismatch_q;
  assign serial_shift_rstn  = srstn_q;
  assign serial_clock       = sclk_q;
  assign serial_load        = sload_q;
  assign serial_data_out    = sdo_q;

endmodule

// File: doc/gpio_cfg_chain_ctrl.md
Name: gpio_cfg_chain_ctrl

Overview:
- Parametrised master for the daisy-chained GPIO pad configuration shift chain (serial_clock/serial_load/serial_data through per-pad control blocks).
- Holds a shadow register file of one CTRL_BITS word per pad. On command it serialises the whole image into the chain at a programmable bit rate, then pulses load.
- Samples the bits returning from the chain tail and checks them against the previously committed image, flagging chain corruption.
- Sits between the SoC register bus and the pad bank.

Parameters:
NUM_PADS, 6, number of pads (control blocks) in the chain
CTRL_BITS, 16, configuration bits per pad
DIV_W, 8, width of clock-divide field
DEFAULT_CFG, 16'h3000, reset value of every shadow word (CTRL_BITS wide)

Ports:
mclk  input  1  block clock
reset  input  1  synchronous, active-high reset
cfg_wr  input  1  shadow write strobe
cfg_addr  input  $clog2(NUM_PADS)  pad index for write/read
cfg_wdata  input  CTRL_BITS  shadow write data
cfg_rdata  output  CTRL_BITS  shadow word at cfg_addr (combinational read)
start  input  1  begin shift+load sequence (single-cycle pulse)
clk_div  input  DIV_W  half-period of serial_clock minus 1, in mclk cycles
busy  output  1  sequence in progress
done  output  1  one-cycle pulse at sequence end
rb_mismatch  output  1  sticky: returned stream differed from committed image
serial_shift_rstn  output  1  chain shift-register reset, active low
serial_clock  output  1  chain shift clock
serial_load  output  1  chain load strobe
serial_data_out  output  1  data into chain head
serial_data_in  input  1  data from chain tail

Behaviour:
- Reset (sync, active-high):
  - all shadow words = DEFAULT_CFG; committed image = DEFAULT_CFG, committed_valid=0.
  - state IDLE; busy=0, done=0, rb_mismatch=0.
  - serial_clock=0, serial_load=0, serial_data_out=0.
  - serial_shift_rstn=0 during reset and for the first cycle after; 1 otherwise (registered ~reset).
- Chain length L = NUM_PADS*CTRL_BITS. Bit counter is $clog2(L+1) wide. Phase counter is DIV_W wide.
- Shadow writes: cfg_wr with cfg_addr<NUM_PADS writes in IDLE only.
  - Writes while busy are dropped.
  - Out-of-range addresses are ignored and read back as 0.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, GAP, LOAD, DONE.
  - IDLE: start=1 samples clk_div into d, clears rb_mismatch, and goes to SHIFT_LO with bit index k=0. busy rises the next cycle. start while busy is ignored.
  - SHIFT_LO: serial_clock=0, serial_data_out=stream bit k, held d+1 cycles. On its last cycle, serial_data_in is sampled as returned bit k; then go to SHIFT_HI.
  - SHIFT_HI: serial_clock=1 for d+1 cycles. Then k++. If k==L go to GAP, else SHIFT_LO.
  - GAP: serial_clock=0, serial_data_out=0 for d+1 cycles, then LOAD.
  - LOAD: serial_load=1 for d+1 cycles. On exit: committed image := shadow image, committed_valid=1.
  - DONE: one cycle with done=1 and busy=0, then IDLE.
- Stream order: pad NUM_PADS-1 first, MSB first within each word. Bit k = shadow[NUM_PADS-1-k/CTRL_BITS][CTRL_BITS-1-k%CTRL_BITS].
- Readback check: if committed_valid=1 and returned bit k != committed-image bit k (same ordering), set rb_mismatch. It stays set until the next accepted start or reset. With committed_valid=0 no comparison is made.
- Busy duration: (2L+2)(d+1) cycles. d=0 is legal: serial_clock toggles every mclk. Max d = 2^DIV_W-1.
- clk_div changes mid-sequence have no effect.
- Reset mid-sequence: immediate return to IDLE. No load pulse. The committed image is reset to DEFAULT_CFG.
- serial_data_out changes only on the SHIFT_LO entry cycle (stable across the rising serial_clock).

Test Plan:
- Reset values: after reset, read all 6 addresses → 16'h3000. busy=0, rb_mismatch=0, serial_shift_rstn low for 2 cycles.
- Full load, d=0, L=96, shadow[i]=16'hA500+i, start:
  - busy high 194 cycles, 96 serial_clock rising edges, serial_load high 1 cycle, done pulse.
  - First 16 bits out = 16'hA505 MSB first.
  - 96-bit chain model holds the image.
- Divider d=3: serial_clock high 4 cycles, low 4 cycles; busy 776 cycles; serial_load high 4 cycles.
- Readback:
  - Second start with intact chain model → rb_mismatch=0.
  - Flip chain-model bit 17 before the third start → rb_mismatch=1 after returned bit 17, cleared by the next start.
- Collisions: cfg_wr and a second start during busy are both ignored (shadow unchanged, a single done).
- Reset asserted at bit 40: next cycle IDLE, serial_clock=0, no serial_load. Fresh start completes normally with rb_mismatch=0 (committed_valid=0).
